// File: rtl/proc_vec_pkg.sv
// ============================================================================
// Module      : proc_vec_pkg
// Description : Shared constants for the vector processor decode stage:
//               sizes, opcodes, instruction field positions, state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_vec_pkg;

  localparam int VLEN     = 32;
  localparam int NREG     = 8;
  localparam int FILL_CYC = 2;

  // Instruction field bit positions
  localparam int OP_HI  = 13;
  localparam int OP_LO  = 10;
  localparam int VD_HI  = 9;
  localparam int VD_LO  = 7;
  localparam int VS1_HI = 6;
  localparam int VS1_LO = 4;
  localparam int VS2_HI = 2;
  localparam int VS2_LO = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_VXOR  = 4'd1;
  localparam logic [3:0] OP_VSHL  = 4'd2;
  localparam logic [3:0] OP_VSHR  = 4'd3;
  localparam logic [3:0] OP_VROTL = 4'd4;
  localparam logic [3:0] OP_VROTR = 4'd5;
  localparam logic [3:0] OP_VADD  = 4'd6;
  localparam logic [3:0] OP_VSUB  = 4'd7;
  localparam logic [3:0] OP_VLD   = 4'd8;
  localparam logic [3:0] OP_VST   = 4'd9;
  localparam logic [3:0] OP_END   = 4'd15;

  // Launch/run state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  // Opcodes 10..14 are reserved
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'd10) && (op <= 4'd14);
  endfunction

endpackage

`default_nettype wire

// File: rtl/banco_vreg.sv
// ============================================================================
// Module      : banco_vreg
// Description : NREG x VLEN vector register file, 2 async reads, 1 sync write.
//               Define ID_WB_BYPASS_EN for same-cycle write-through on reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banco_vreg #(
  parameter int VLEN = proc_vec_pkg::VLEN,
  parameter int NREG = proc_vec_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] rd_idx_a,
  input  logic [$clog2(NREG)-1:0] rd_idx_b,
  output logic [VLEN-1:0]         rd_data_a,
  output logic [VLEN-1:0]         rd_data_b,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_idx,
  input  logic [VLEN-1:0]         wr_data
);

  logic [VLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en) begin
      r_regs[wr_idx] <= wr_data;
    end
  end

`ifdef ID_WB_BYPASS_EN
  // A write landing this cycle is visible to readers of the same index
  always_comb begin
    rd_data_a = r_regs[rd_idx_a];
    rd_data_b = r_regs[rd_idx_b];
    if (wr_en && (wr_idx == rd_idx_a)) rd_data_a = wr_data;
    if (wr_en && (wr_idx == rd_idx_b)) rd_data_b = wr_data;
  end
`else
  always_comb begin
    rd_data_a = r_regs[rd_idx_a];
    rd_data_b = r_regs[rd_idx_b];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/etapa_id_ctrl.sv
// ============================================================================
// Module      : etapa_id_ctrl
// Description : Decode stage: algorithm launch FSM, vector register file and
//               ID/EX register. Build option ID_WB_BYPASS_EN enables RF bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module etapa_id_ctrl #(
  parameter int VLEN     = proc_vec_pkg::VLEN,
  parameter int NREG     = proc_vec_pkg::NREG,
  parameter int FILL_CYC = proc_vec_pkg::FILL_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      alg_sel,
  input  logic [13:0]     instruccion,
  input  logic            wb_we,
  input  logic [2:0]      wb_vd,
  input  logic [VLEN-1:0] wb_data,
  output logic [2:0]      sel_dir,
  output logic            sel_pc,
  output logic            ex_valid,
  output logic [3:0]      ex_op,
  output logic [2:0]      ex_vd,
  output logic [VLEN-1:0] ex_a,
  output logic [VLEN-1:0] ex_b,
  output logic [3:0]      ex_imm,
  output logic            busy,
  output logic            alg_done,
  output logic            illegal
);

  import proc_vec_pkg::*;

  localparam int CW = $clog2(FILL_CYC + 1);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_fill_cnt;
  logic [2:0]      r_sel_dir;
  logic            r_ex_valid;
  logic [3:0]      r_ex_op;
  logic [2:0]      r_ex_vd;
  logic [VLEN-1:0] r_ex_a;
  logic [VLEN-1:0] r_ex_b;
  logic [3:0]      r_ex_imm;
  logic            r_alg_done;
  logic            r_illegal;

  logic [3:0]      w_op;
  logic [2:0]      w_vd;
  logic [2:0]      w_vs1;
  logic [2:0]      w_vs2;
  logic [3:0]      w_imm;
  logic [VLEN-1:0] w_rd_a;
  logic [VLEN-1:0] w_rd_b;

  assign w_op  = instruccion[OP_HI:OP_LO];
  assign w_vd  = instruccion[VD_HI:VD_LO];
  assign w_vs1 = instruccion[VS1_HI:VS1_LO];
  assign w_vs2 = instruccion[VS2_HI:VS2_LO];
  assign w_imm = instruccion[IMM_HI:IMM_LO];

  banco_vreg #(
    .VLEN (VLEN),
    .NREG (NREG)
  ) u_banco_vreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_a  (w_vs1),
    .rd_idx_b  (w_vs2),
    .rd_data_a (w_rd_a),
    .rd_data_b (w_rd_b),
    .wr_en     (wb_we),
    .wr_idx    (wb_vd),
    .wr_data   (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fill_cnt <= '0;
      r_sel_dir  <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_vd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_imm   <= '0;
      r_alg_done <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_ex_valid <= 1'b0;
      r_alg_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_LAUNCH;
            r_sel_dir <= alg_sel;
            r_illegal <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          r_state    <= ST_FILL;
          r_fill_cnt <= CW'(FILL_CYC);
        end
        ST_FILL: begin
          // Wait out the PC register and ROM latency after the redirect
          if (r_fill_cnt == CW'(1)) begin
            r_state <= ST_RUN;
          end else begin
            r_fill_cnt <= r_fill_cnt - CW'(1);
          end
        end
        ST_RUN: begin
          if (w_op == OP_END) begin
            r_alg_done <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (is_illegal(w_op)) begin
            r_illegal <= 1'b1;
            r_ex_op   <= OP_NOP;
          end else begin
            r_ex_valid <= 1'b1;
            r_ex_op    <= w_op;
            r_ex_vd    <= w_vd;
            r_ex_a     <= w_rd_a;
            r_ex_b     <= w_rd_b;
            r_ex_imm   <= w_imm;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel_dir  = r_sel_dir;
  assign sel_pc   = (r_state == ST_LAUNCH);
  assign busy     = (r_state != ST_IDLE);
  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex_op;
  assign ex_vd    = r_ex_vd;
  assign ex_a     = r_ex_a;
  assign ex_b     = r_ex_b;
  assign ex_imm   = r_ex_imm;
  assign alg_done = r_alg_done;
  assign illegal  = r_illegal;

endmodule

`default_nettype wire
